ddr_burst_seq: RTL and testbench

Sequencer between the Wishbone port arbiter's internal interface and the Altera DDR controller local interface, in the sdram_clk domain. Consumes one arbitrated access at a time:
- Reads become a single aligned DDR burst sized by the granted port's buffer width.
- Writes become single-word DDR writes.

It returns per-word acks with the word address so the granted port can fill its buffer. It drives the idle indication the arbiter uses to decide when it may switch ports.

---
 rtl/ddr_burst_seq.sv | 152 +++++++++++++++
 tb/tb_ddr_burst_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_burst_seq.sv
// Burst sequencer between the Wishbone port arbiter and the Altera DDR local interface.
// Reads become one aligned burst sized by the port buffer width; writes become single-word writes.
module ddr_burst_seq #(
    parameter int DDR_ADR_W     = 24,
    parameter int MAX_BUF_WIDTH = 3,
    parameter int HOLDOFF       = 2
) (
    input  logic                     sdram_clk,
    input  logic                     sdram_rst_n,
    input  logic [31:0]              adr_i,
    input  logic [31:0]              dat_i,
    input  logic [3:0]               sel_i,
    input  logic                     we_i,
    input  logic                     acc_i,
    input  logic [3:0]               buf_width_i,
    output logic [31:0]              adr_o,
    output logic [31:0]              dat_o,
    output logic                     ack_o,
    output logic                     idle_o,
    input  logic                     ddr_init_done_i,
    input  logic                     ddr_ready_i,
    output logic [DDR_ADR_W-1:0]     ddr_adr_o,
    output logic                     ddr_read_req_o,
    output logic                     ddr_write_req_o,
    output logic                     ddr_burstbegin_o,
    output logic [MAX_BUF_WIDTH:0]   ddr_size_o,
    output logic [31:0]              ddr_wdata_o,
    output logic [3:0]               ddr_be_o,
    input  logic [31:0]              ddr_rdata_i,
    input  logic                     ddr_rdata_valid_i
);

    localparam int CW = MAX_BUF_WIDTH + 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t         state, state_next;
    logic [31:0]    adr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     sel_q;
    logic [3:0]     bw_q;
    logic [CW-1:0]  cnt_q;
    logic [1:0]     hold_cnt;

    logic [3:0]     bw_in;
    logic [29:0]    blk_mask;
    logic [CW-1:0]  burst_len;
    logic           last_beat;

    assign bw_in     = (buf_width_i > 4'(MAX_BUF_WIDTH)) ? 4'(MAX_BUF_WIDTH) : buf_width_i;
    assign blk_mask  = ~((30'd1 << bw_in) - 30'd1);
    assign burst_len = CW'(1) << bw_q;
    assign last_beat = ddr_rdata_valid_i && ((cnt_q + CW'(1)) == burst_len);

    // NOTE: state and datapath registers use non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) state <= S_INIT;
        else              state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next       = state;
        ddr_adr_o        = '0;
        ddr_read_req_o   = 1'b0;
        ddr_write_req_o  = 1'b0;
        ddr_burstbegin_o = 1'b0;
        ddr_size_o       = '0;
        ddr_wdata_o      = '0;
        ddr_be_o         = '0;
        case (state)
            S_INIT: if (ddr_init_done_i) state_next = S_IDLE;
            S_IDLE: if (acc_i) state_next = we_i ? S_WR : S_RD_REQ;
            S_WR: begin
                ddr_write_req_o  = 1'b1;
                ddr_burstbegin_o = 1'b1;
                ddr_size_o       = CW'(1);
                ddr_adr_o        = adr_q[DDR_ADR_W+1:2];
                ddr_wdata_o      = wdata_q;
                ddr_be_o         = sel_q;
                if (ddr_ready_i) state_next = S_DONE;
            end
            S_RD_REQ: begin
                ddr_read_req_o   = 1'b1;
                ddr_burstbegin_o = 1'b1;
                ddr_size_o       = burst_len;
                ddr_adr_o        = adr_q[DDR_ADR_W+1:2];
                if (ddr_ready_i) state_next = last_beat ? S_DONE : S_RD_DATA;
            end
            S_RD_DATA: if (last_beat) state_next = S_DONE;
            S_DONE: if (hold_cnt == 2'(HOLDOFF - 1)) state_next = S_IDLE;
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            adr_q    <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            bw_q     <= '0;
            cnt_q    <= '0;
            hold_cnt <= '0;
            ack_o    <= 1'b0;
            adr_o    <= '0;
            dat_o    <= '0;
            idle_o   <= 1'b0;
        end else begin
            ack_o    <= 1'b0;
            idle_o   <= (state_next == S_IDLE);
            hold_cnt <= (state == S_DONE) ? hold_cnt + 2'd1 : 2'd0;
            case (state)
                S_IDLE: begin
                    if (acc_i && we_i) begin
                        adr_q   <= adr_i;
                        wdata_q <= dat_i;
                        sel_q   <= sel_i;
                    end else if (acc_i) begin
                        bw_q  <= bw_in;
                        adr_q <= adr_i & {blk_mask, 2'b11};
                        cnt_q <= '0;
                    end
                end
                S_WR: begin
                    if (ddr_ready_i) begin
                        ack_o <= 1'b1;
                        adr_o <= adr_q & ~32'h3;
                    end
                end
                S_RD_REQ, S_RD_DATA: begin
                    // Base is block-aligned, so base+cnt stays inside the burst's block.
                    if (ddr_rdata_valid_i) begin
                        ack_o <= 1'b1;
                        dat_o <= ddr_rdata_i;
                        adr_o <= {adr_q[31:2] + 30'(cnt_q), 2'b00};
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_burst_seq.sv
// Directed self-checking bench for ddr_burst_seq: init, read bursts, clamp, write stall,
// stray/early data and reset in the middle of a burst.
module tb_ddr_burst_seq;

    logic        sdram_clk = 1'b0;
    logic        sdram_rst_n;
    logic [31:0] adr_i, dat_i;
    logic [3:0]  sel_i;
    logic        we_i, acc_i;
    logic [3:0]  buf_width_i;
    logic [31:0] adr_o, dat_o;
    logic        ack_o, idle_o;
    logic        ddr_init_done_i, ddr_ready_i;
    logic [23:0] ddr_adr_o;
    logic        ddr_read_req_o, ddr_write_req_o, ddr_burstbegin_o;
    logic [3:0]  ddr_size_o;
    logic [31:0] ddr_wdata_o;
    logic [3:0]  ddr_be_o;
    logic [31:0] ddr_rdata_i;
    logic        ddr_rdata_valid_i;

    int errors = 0;
    int checks = 0;
    int acks;

    ddr_burst_seq #(.DDR_ADR_W(24), .MAX_BUF_WIDTH(3), .HOLDOFF(2)) dut (
        .sdram_clk        (sdram_clk),
        .sdram_rst_n      (sdram_rst_n),
        .adr_i            (adr_i),
        .dat_i            (dat_i),
        .sel_i            (sel_i),
        .we_i             (we_i),
        .acc_i            (acc_i),
        .buf_width_i      (buf_width_i),
        .adr_o            (adr_o),
        .dat_o            (dat_o),
        .ack_o            (ack_o),
        .idle_o           (idle_o),
        .ddr_init_done_i  (ddr_init_done_i),
        .ddr_ready_i      (ddr_ready_i),
        .ddr_adr_o        (ddr_adr_o),
        .ddr_read_req_o   (ddr_read_req_o),
        .ddr_write_req_o  (ddr_write_req_o),
        .ddr_burstbegin_o (ddr_burstbegin_o),
        .ddr_size_o       (ddr_size_o),
        .ddr_wdata_o      (ddr_wdata_o),
        .ddr_be_o         (ddr_be_o),
        .ddr_rdata_i      (ddr_rdata_i),
        .ddr_rdata_valid_i(ddr_rdata_valid_i)
    );

    always #5 sdram_clk = ~sdram_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs set after this are sampled on the next edge.
    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    initial begin
        sdram_rst_n = 1'b0;
        adr_i = '0; dat_i = '0; sel_i = '0; we_i = 1'b0; acc_i = 1'b1;
        buf_width_i = '0; ddr_init_done_i = 1'b0; ddr_ready_i = 1'b0;
        ddr_rdata_i = '0; ddr_rdata_valid_i = 1'b0;
        tick(); tick();
        check("rst_ack", ack_o, 0);
        check("rst_idle", idle_o, 0);
        check("rst_adr", adr_o, 0);
        check("rst_dat", dat_o, 0);
        check("rst_ddr", {ddr_read_req_o, ddr_write_req_o, ddr_burstbegin_o, ddr_adr_o,
                          ddr_size_o, ddr_be_o}, 0);
        sdram_rst_n = 1'b1;

        // INIT holds off requests even with acc_i asserted
        for (int i = 0; i < 10; i++) begin
            tick();
            check("init_rreq", ddr_read_req_o, 0);
            check("init_idle", idle_o, 0);
        end
        acc_i = 1'b0;
        ddr_init_done_i = 1'b1;
        tick();
        check("init_to_idle", idle_o, 1);

        // Aligned 8-beat read
        adr_i = 32'h0000_1034; buf_width_i = 4'd3; we_i = 1'b0; acc_i = 1'b1;
        tick();
        acc_i = 1'b0; ddr_ready_i = 1'b1;
        check("rd_req", {ddr_read_req_o, ddr_burstbegin_o, ddr_write_req_o}, 3'b110);
        check("rd_adr", ddr_adr_o, 24'h000408);
        check("rd_size", ddr_size_o, 8);
        check("rd_idle", idle_o, 0);
        tick();
        ddr_ready_i = 1'b0;
        check("rd_req_drop", ddr_read_req_o, 0);
        for (int i = 0; i < 8; i++) begin
            ddr_rdata_valid_i = 1'b1;
            ddr_rdata_i = 32'hD0D0_0000 | i;
            tick();
            check("rd_ack", ack_o, 1);
            check("rd_ack_adr", adr_o, 32'h1020 + 4 * i);
            check("rd_ack_dat", dat_o, 32'hD0D0_0000 | i);
        end
        ddr_rdata_valid_i = 1'b0;
        tick();
        check("rd_ack_end", ack_o, 0);
        check("rd_hold_idle", idle_o, 0);
        tick();
        check("rd_back_idle", idle_o, 1);

        // Clamp: width 5 becomes 8 beats; extra beats in DONE are stray
        adr_i = 32'h0000_2000; buf_width_i = 4'd5; acc_i = 1'b1;
        tick();
        acc_i = 1'b0; ddr_ready_i = 1'b1;
        check("clamp_size", ddr_size_o, 8);
        check("clamp_adr", ddr_adr_o, 24'h000800);
        tick();
        ddr_ready_i = 1'b0;
        acks = 0;
        ddr_rdata_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ddr_rdata_i = 32'h5A00_0000 | i;
            tick();
            if (ack_o) acks++;
        end
        ddr_rdata_valid_i = 1'b0;
        check("clamp_acks", acks, 8);
        check("clamp_idle", idle_o, 1);

        // Write with 4 stall cycles
        we_i = 1'b1; adr_i = 32'h0000_0200; dat_i = 32'hDEAD_BEEF; sel_i = 4'b0110; acc_i = 1'b1;
        tick();
        acc_i = 1'b0; we_i = 1'b0;
        for (int j = 0; j < 5; j++) begin
            ddr_ready_i = (j == 4);
            check("wr_req", {ddr_write_req_o, ddr_burstbegin_o, ddr_read_req_o}, 3'b110);
            check("wr_fields", {ddr_adr_o, ddr_wdata_o, ddr_be_o, ddr_size_o},
                  {24'h000080, 32'hDEAD_BEEF, 4'b0110, 4'd1});
            check("wr_no_ack", ack_o, 0);
            tick();
        end
        ddr_ready_i = 1'b0;
        check("wr_ack", ack_o, 1);
        check("wr_ack_adr", adr_o, 32'h200);
        check("wr_req_drop", ddr_write_req_o, 0);
        tick();
        check("wr_ack_once", ack_o, 0);
        check("wr_hold_idle", idle_o, 0);
        tick();
        check("wr_back_idle", idle_o, 1);

        // Stray beat in IDLE
        ddr_rdata_valid_i = 1'b1;
        tick();
        ddr_rdata_valid_i = 1'b0;
        check("stray_ack", ack_o, 0);

        // Data in the same cycle as ready, 2-beat burst
        adr_i = 32'h0000_4000; buf_width_i = 4'd1; acc_i = 1'b1;
        tick();
        acc_i = 1'b0;
        check("early_size", ddr_size_o, 2);
        ddr_ready_i = 1'b1; ddr_rdata_valid_i = 1'b1; ddr_rdata_i = 32'h11;
        tick();
        check("early_ack0", {ack_o, adr_o, dat_o}, {1'b1, 32'h4000, 32'h11});
        ddr_ready_i = 1'b0; ddr_rdata_i = 32'h22;
        tick();
        check("early_ack1", {ack_o, adr_o, dat_o}, {1'b1, 32'h4004, 32'h22});
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack_o) acks++;
        end
        ddr_rdata_valid_i = 1'b0;
        check("early_no_extra", acks, 0);
        check("early_idle", idle_o, 1);

        // Single-beat burst completing in RD_REQ
        adr_i = 32'h0000_5004; buf_width_i = 4'd0; acc_i = 1'b1;
        tick();
        acc_i = 1'b0;
        check("single_req", {ddr_size_o, ddr_adr_o}, {4'd1, 24'h001401});
        ddr_ready_i = 1'b1; ddr_rdata_valid_i = 1'b1; ddr_rdata_i = 32'h33;
        tick();
        ddr_ready_i = 1'b0; ddr_rdata_valid_i = 1'b0;
        check("single_ack", {ack_o, adr_o, dat_o}, {1'b1, 32'h5004, 32'h33});
        check("single_done", {ddr_read_req_o, idle_o}, 2'b00);
        tick(); tick();
        check("single_idle", idle_o, 1);

        // Reset after the 3rd beat of a burst
        adr_i = 32'h0000_8000; buf_width_i = 4'd3; acc_i = 1'b1;
        tick();
        acc_i = 1'b0; ddr_ready_i = 1'b1;
        tick();
        ddr_ready_i = 1'b0; ddr_rdata_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ddr_rdata_i = 32'hBB00_0000 | i;
            tick();
        end
        check("mid_ack3", {ack_o, adr_o}, {1'b1, 32'h8008});
        sdram_rst_n = 1'b0;
        #1;
        check("mid_rst_out", {ack_o, idle_o, adr_o, dat_o}, 66'd0);
        check("mid_rst_ddr", {ddr_read_req_o, ddr_burstbegin_o, ddr_size_o, ddr_adr_o}, 0);
        tick();
        sdram_rst_n = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack_o) acks++;
        end
        ddr_rdata_valid_i = 1'b0;
        check("mid_no_acks", acks, 0);
        check("mid_idle", idle_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
